// File: rtl/jk_updown_counter.sv
// jk_updown_counter
//   Modulo-MODULUS up/down counter with synchronous parallel load, built on a
//   bank of WIDTH JK flip-flop cells driven in toggle form.
//   The per-bit J/K excitation and a terminal-count flag are exported so that
//   stages can be cascaded.
//
// Build option:
//   JK_CNT_SATURATE_EN  when defined, counting stops at the limit instead of
//                       wrapping. Load, reset and preset are unaffected.
//
// Parameters:
//   WIDTH    counter and data width in bits
//   MODULUS  count range is 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clk   in   rising-edge clock
//   rstn  in   asynchronous active-low reset; count goes to 0 (wins over pstn)
//   pstn  in   asynchronous active-low preset; count goes to MODULUS-1
//   en    in   count enable
//   up    in   direction: 1 = increment, 0 = decrement
//   ld    in   synchronous parallel load (wins over en)
//   d     in   load value; values >= MODULUS are clamped to MODULUS-1
//   q     out  current count
//   tc    out  terminal count, combinational
//   j     out  J excitation per bit, combinational
//   k     out  K excitation per bit, combinational (always equal to j)

module jk_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pstn,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  // Compares run one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] nxt;

  assign q_ext   = {1'b0, q};
  assign d_ext   = {1'b0, d};
  assign at_max  = (q_ext == MAX_EXT);
  assign at_zero = (q == '0);

  always_comb begin
    nxt = q;
    if (ld) begin
      nxt = (d_ext >= MOD_EXT) ? MAX : d;
    end else if (en) begin
      if (up) begin
`ifdef JK_CNT_SATURATE_EN
        nxt = at_max ? q : q + WIDTH'(1);
`else
        nxt = at_max ? '0 : q + WIDTH'(1);
`endif
      end else begin
`ifdef JK_CNT_SATURATE_EN
        nxt = at_zero ? q : q - WIDTH'(1);
`else
        nxt = at_zero ? MAX : q - WIDTH'(1);
`endif
      end
    end
  end

  // Toggle-form excitation: every bit that must change gets J=K=1.
  assign j = q ^ nxt;
  assign k = q ^ nxt;

  assign tc = en & ~ld & ((up & at_max) | (~up & at_zero));

  // JK cell bank: q+ = J&~q | ~K&q, with async clear/preset per bit.
  always_ff @(posedge clk or negedge rstn or negedge pstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (!pstn) begin
      q <= MAX;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb_jk_updown_counter
//   Directed bench for jk_updown_counter. Two instances share the clock:
//   dut_a (WIDTH=4, MODULUS=16) for reset/preset and the full sweep,
//   dut_b (WIDTH=4, MODULUS=10) for wrap, clamp and mid-count preset.
//   Honors JK_CNT_SATURATE_EN so it can be built against either variant.
`timescale 1ps/1ps

module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       rstn, pstn;

  logic       a_en, a_up, a_ld;
  logic [3:0] a_d, a_q, a_j, a_k;
  logic       a_tc;

  logic       b_rstn, b_pstn;
  logic       b_en, b_up, b_ld;
  logic [3:0] b_d, b_q, b_j, b_k;
  logic       b_tc;

  int checks = 0;
  int errors = 0;

  always #5000 clk = ~clk;

  jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_a (
    .clk(clk), .rstn(rstn), .pstn(pstn), .en(a_en), .up(a_up), .ld(a_ld),
    .d(a_d), .q(a_q), .tc(a_tc), .j(a_j), .k(a_k)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
    .clk(clk), .rstn(b_rstn), .pstn(b_pstn), .en(b_en), .up(b_up), .ld(b_ld),
    .d(b_d), .q(b_q), .tc(b_tc), .j(b_j), .k(b_k)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle well inside the high phase.
  task automatic tick();
    @(posedge clk);
    #100;
  endtask

`ifdef JK_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [3:0] exp_q, exp_n;

  initial begin
    rstn = 1'b0; pstn = 1'b1;
    b_rstn = 1'b0; b_pstn = 1'b1;
    a_en = 0; a_up = 0; a_ld = 0; a_d = '0;
    b_en = 0; b_up = 0; b_ld = 0; b_d = '0;

    // ---- async reset / preset on the MODULUS=16 instance ----
    #2000;
    chk("rst_q", 32'(a_q), 32'd0);
    chk("rst_tc", 32'(a_tc), 32'd0);
    rstn = 1'b1; pstn = 1'b0;
    #1;
    chk("preset_q", 32'(a_q), 32'd15);
    rstn = 1'b0;
    #1;
    chk("both_low_q", 32'(a_q), 32'd0);

    // release mid-low-phase
    @(negedge clk);
    #2000;
    rstn = 1'b1; pstn = 1'b1;
    b_rstn = 1'b1; b_pstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", 32'(a_q), 32'd0);
      chk("hold_j", 32'(a_j), 32'd0);
      chk("hold_k", 32'(a_k), 32'd0);
    end

    // ---- up wrap, MODULUS=10 ----
    b_ld = 1; b_d = 4'd8;
    #1;
    chk("ld_tc", 32'(b_tc), 32'd0);
    tick();
    chk("ld8_q", 32'(b_q), 32'd8);
    b_ld = 0; b_en = 1; b_up = 1;
    #1;
    chk("up8_tc", 32'(b_tc), 32'd0);
    tick();
    chk("up_q9", 32'(b_q), 32'd9);
    chk("up_q9_tc", 32'(b_tc), 32'd1);
    chk("up_q9_j", 32'(b_j), SAT ? 32'h0 : 32'h9);
    chk("up_q9_k", 32'(b_k), SAT ? 32'h0 : 32'h9);
    tick();
    chk("up_wrap_q", 32'(b_q), SAT ? 32'd9 : 32'd0);
    chk("up_wrap_tc", 32'(b_tc), SAT ? 32'd1 : 32'd0);
    tick();
    chk("up_next_q", 32'(b_q), SAT ? 32'd9 : 32'd1);

    // ---- down wrap from 1 ----
    b_en = 0; b_ld = 1; b_d = 4'd1;
    tick();
    chk("ld1_q", 32'(b_q), 32'd1);
    b_ld = 0; b_en = 1; b_up = 0;
    #1;
    chk("dn1_tc", 32'(b_tc), 32'd0);
    tick();
    chk("dn_q0", 32'(b_q), 32'd0);
    chk("dn_q0_tc", 32'(b_tc), 32'd1);
    chk("dn_q0_j", 32'(b_j), SAT ? 32'h0 : 32'h9);
    chk("dn_q0_k", 32'(b_k), SAT ? 32'h0 : 32'h9);
    tick();
    chk("dn_wrap_q", 32'(b_q), SAT ? 32'd0 : 32'd9);
    chk("dn_wrap_tc", 32'(b_tc), SAT ? 32'd1 : 32'd0);

    // ---- load clamp and ld-over-en priority ----
    b_ld = 1; b_en = 1; b_up = 1; b_d = 4'd13;
    #1;
    chk("clamp_tc", 32'(b_tc), 32'd0);
    tick();
    chk("clamp_q", 32'(b_q), 32'd9);
    b_d = 4'd5;
    tick();
    chk("ld5_q", 32'(b_q), 32'd5);

    // ---- mid-count async preset ----
    b_ld = 0; b_en = 1; b_up = 1;
    tick();
    chk("cnt6_q", 32'(b_q), 32'd6);
    @(negedge clk);
    #100;
    b_pstn = 1'b0;
    #1;
    chk("mid_preset_q", 32'(b_q), 32'd9);
    #2;
    b_pstn = 1'b1;
    #1;
    chk("post_preset_q", 32'(b_q), 32'd9);
    chk("post_preset_tc", 32'(b_tc), 32'd1);
    tick();
    chk("after_preset_q", 32'(b_q), SAT ? 32'd9 : 32'd0);

    // ---- full sweep, MODULUS=16: 32 up then 32 down ----
    exp_q = 4'd0;
    a_en = 1;
    for (int i = 0; i < 64; i++) begin
      a_up = (i < 32);
      if (a_up) exp_n = (SAT && exp_q == 4'd15) ? exp_q : exp_q + 4'd1;
      else      exp_n = (SAT && exp_q == 4'd0)  ? exp_q : exp_q - 4'd1;
      #1;
      chk("sweep_j", 32'(a_j), 32'(exp_q ^ exp_n));
      chk("sweep_k", 32'(a_k), 32'(exp_q ^ exp_n));
      tick();
      exp_q = exp_n;
      chk("sweep_q", 32'(a_q), 32'(exp_q));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/jk_updown_counter.md
# jk_updown_counter

Synchronous modulo-N up/down counter with synchronous parallel load, built on a bank of WIDTH JK flip-flop cells driven in toggle form. It also exports the per-bit J/K excitation vectors and a terminal-count flag for cascading. It is the consumer stage of the JK cell: excitation logic plus cells form a textbook counter for the chapter's sequential-circuit exercises.

## Interface
- WIDTH, 4, counter and data width in bits
- MODULUS, 16, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2^WIDTH
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous, active-low reset; forces count to 0
- pstn  input  1  asynchronous, active-low preset; forces count to MODULUS-1
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- ld  input  1  synchronous parallel load
- d  input  WIDTH  load value
- q  output  WIDTH  current count
- tc  output  1  terminal count, combinational
- j  output  WIDTH  J excitation per bit, combinational
- k  output  WIDTH  K excitation per bit, combinational

## Operation
- Async priority: rstn low -> q = 0; else pstn low -> q = MODULUS-1. Both low -> q = 0, because rstn wins. Async effect is immediate, not clock-qualified.
- Sync priority on posedge clk when rstn = pstn = 1:
  - ld = 1: next = d. If d >= MODULUS, next = MODULUS-1 (clamp).
  - else en = 1, up = 1: next = q+1, and MODULUS-1 wraps to 0.
  - else en = 1, up = 0: next = q-1, and 0 wraps to MODULUS-1.
  - else: next = q (hold).
- Excitation is toggle form: j = k = q ^ next. A bit that changes gets J=K=1; an unchanged bit gets J=K=0. j and k are always bit-identical.
- tc = en & ~ld & ((up & q == MODULUS-1) | (~up & q == 0)).
- Arithmetic is done at WIDTH+1 bits internally, so the MODULUS-1 compare and the clamp never overflow.

## Timing
- Reset values: q = 0. tc = 0 unless en = 1 and up = 0 at reset. j = k = 0 while en = ld = 0.
- Latency: one clock from ld/en sampled to q updated. tc, j and k follow q and inputs combinationally within the same cycle.
- Async release: the first active edge is the first posedge after both rstn and pstn are high. Release must meet recovery relative to clk; the bench deasserts mid-low-phase.
- Reset or preset asserted mid-count overrides any pending ld/en on that edge.
- Simultaneous ld and en: ld wins, and tc = 0 in that cycle.
- Direction change takes effect on the next edge with no dead cycle.

## Configuration
- JK_CNT_SATURATE_EN:
  - Defined: counting saturates. Up at MODULUS-1 holds, down at 0 holds, and j = k = 0 for that edge. tc still asserts at the limit.
  - Undefined: wrap-around as in Operation.
  - Load, reset and preset behaviour is identical either way.

## Test plan
- Reset/preset:
  - rstn=0, pstn=1 -> q=0.
  - rstn=1, pstn=0 -> q=15 immediately (WIDTH=4, MODULUS=16).
  - Both 0 -> q=0.
  - Release both, en=0 -> q holds 0 across 3 edges; j=k=0.
- Up wrap (MODULUS=10): load d=8, then en=1, up=1 for 3 edges -> q = 9, 0, 1.
  - tc=1 only while q=9.
  - At q=9: j=k=4'b1001.
  - Under JK_CNT_SATURATE_EN, q = 9, 9, 9 instead.
- Down wrap (MODULUS=10): from q=1, en=1, up=0 for 2 edges -> q = 0, 9.
  - tc=1 while q=0.
  - At q=0: j=k=4'b1001.
- Load clamp and priority (MODULUS=10): ld=1, en=1, d=13 -> q=9 after one edge; tc=0 during the load cycle.
  - ld=1, d=5 -> q=5.
- Mid-count async: counting up at q=6, pulse pstn low for 3 ps between edges -> q=9 immediately (MODULUS=10).
  - Next edge with en=1, up=1 -> q=0.
- Full sweep (WIDTH=4, MODULUS=16): en=1 for 32 edges up, then 32 down.
  - Each step q changes by exactly ±1 mod 16.
  - j == k == q_prev ^ q_next at every edge.
